ele_run_ctrl: RTL
=================

# ele_run_ctrl

Car motion and door-sequencing controller for the 4-storey elevator. It sits directly downstream of the request processor and consumes the registered effective-request vector. It owns the car position and run mode, which it feeds back to the request processor for request cancellation. It hands a door-open level to the door timer and waits for that timer's completion pulse.

## Interface

Parameters:
- `TRAVEL_CYC`, default 64: clock cycles to travel one floor (2 s at clk32hz). Legal range 2..127.
- `CW`, default 7: width of the travel counter. Must satisfy `2**CW > TRAVEL_CYC`.

Ports:
- `clk`  input  1: system clock (clk32hz).
- `rst_n`  input  1: reset. One clock; reset is synchronous and active-low.
- `all_req`  input  4: effective requests, one-hot per floor, bit0 = floor 1. Registered upstream.
- `endOpen`  input  1: door timer done. High for at least 1 cycle.
- `position`  output  4: car floor, one-hot.
- `ud_mode`  output  2: run mode. 00 stop, 01 up, 10 down. 11 is never driven.
- `opendoor`  output  1: door-open request level to the door timer (its StOpen).
- `moving`  output  1: high while in a travel state.
- `arrive`  output  1: one-cycle pulse when `position` advances.
- `floor_bin`  output  2: binary floor index for the display (0..3).

## Operation

Derived request sets:
- above = `all_req & ~(position | (position-1))`
- below = `all_req & (position-1)`
- here = `all_req & position`

FSM states: IDLE, UP, DOWN, DOOR.

- IDLE, `ud_mode`=00:
  - here≠0 → DOOR. `ud_mode` becomes 01, or 10 when position = 4'b1000, so upstream clears the request.
  - else above≠0 → UP.
  - else below≠0 → DOWN.
  - above and below both set: UP wins.
- UP / DOWN, `ud_mode`=01 / 10, `moving`=1:
  - Travel counter counts 0..`TRAVEL_CYC`-1.
  - At terminal count: `position` shifts one floor (left for UP, right for DOWN), `arrive` pulses, counter clears.
  - The same cycle decides the next state using the next position np:
    - `all_req & np` ≠0 → DOOR (mode held).
    - else requests remain beyond np in the current direction → same state.
    - else requests exist in the opposite direction → opposite travel state.
    - else → IDLE, mode 00.
- DOOR, `opendoor`=1, mode held:
  - First cycle `endOpen`=1 → `opendoor` drops.
  - Re-evaluate with the current position: continue the current direction if requests lie ahead, else reverse if requests lie behind, else IDLE.
  - `all_req` at the current floor while in DOOR is ignored, because upstream clears it.
- Boundaries:
  - UP never shifts past 4'b1000 and DOWN never past 4'b0001. A move beyond an end is suppressed and the block goes to IDLE.
  - `all_req` dropping to 0 mid-travel: the current floor segment completes, then IDLE with no door.
- Reset mid-operation: all state returns to reset values immediately. The position model resyncs to floor 1.

## Timing

- Reset values:
  - `position`=4'b0001, `ud_mode`=00, `opendoor`=0, `moving`=0, `arrive`=0, `floor_bin`=0.
  - FSM in IDLE, counter 0.
- IDLE→UP/DOWN/DOOR: 1 cycle after `all_req` is sampled.
- Floor-to-floor: exactly `TRAVEL_CYC` cycles from entering a travel state to the `arrive` pulse.
- `arrive` and the `position` update are in the same cycle. DOOR or the next state is registered on that same edge.
- DOOR exit: `opendoor` is low the cycle after `endOpen` is sampled high. The next travel starts counting in that cycle.
- All outputs are registered, with no combinational input→output path. `floor_bin` is encoded from registered `position`.

## Structure

- Shared package `ele_pkg`: state encoding (IDLE, UP, DOWN, DOOR), `ud_mode` constants (MODE_STOP=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10), floor one-hot constants, and the default `TRAVEL_CYC`.
- One natural sub-module, `travel_timer`: enable/clear counter with a terminal-count pulse, parameterised by `TRAVEL_CYC` and `CW`.
- The FSM and position register live in the top module.

## Test plan

Run with `TRAVEL_CYC`=4.
1. Reset with `rst_n`=0 for 2 cycles → `position`=0001, `ud_mode`=00, `opendoor`=0, `floor_bin`=0.
2. At floor 1, `all_req`=0100 → UP.
   - `arrive` pulses at cycle 4 (pos 0010) and cycle 8 (pos 0100).
   - DOOR at pos 0100 with `opendoor`=1.
   - Pulse `endOpen` with `all_req`=0 → IDLE, mode 00.
3. At floor 3, `all_req`=1001 → UP to 1000 with door. After `endOpen`, DOWN to 0001 with door, `ud_mode`=10.
4. At floor 2, `all_req`=0010 → DOOR within 1 cycle, `ud_mode`=01, no `arrive`.
5. UP from floor 1 toward 1000; drop `all_req` to 0 at cycle 2 → `arrive` at cycle 4 (pos 0010), then IDLE, `opendoor` stays 0.
6. Assert `rst_n`=0 mid-travel at pos 0100 → next cycle `position`=0001, IDLE, `moving`=0.

Source files
------------

// File: rtl/ele_pkg.sv
// ele_pkg: shared state, mode and floor encodings for the elevator controller
package ele_pkg;
  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_DOOR} state_t;
  localparam logic [1:0] MODE_STOP = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [3:0] FLOOR1 = 4'b0001;
  localparam logic [3:0] FLOOR2 = 4'b0010;
  localparam logic [3:0] FLOOR3 = 4'b0100;
  localparam logic [3:0] FLOOR4 = 4'b1000;
  localparam int TRAVEL_CYC_DEF = 64;
  function automatic logic [3:0] req_above(input logic [3:0] r, input logic [3:0] p);
    return r & ~(p | (p - 4'd1));
  endfunction
  function automatic logic [3:0] req_below(input logic [3:0] r, input logic [3:0] p);
    return r & (p - 4'd1);
  endfunction
  function automatic logic [1:0] floor_enc(input logic [3:0] p);
    return {p[3] | p[2], p[3] | p[1]};
  endfunction
endpackage

// File: rtl/ele_run_ctrl_travel_timer.sv
// travel_timer: floor-to-floor cycle counter with terminal-count pulse
module travel_timer #(
  parameter int TRAVEL_CYC = 64,
  parameter int CW = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);
  logic [CW-1:0] cnt;
  assign tc = en && cnt == CW'(TRAVEL_CYC - 1);
  always_ff @(posedge clk)
    cnt <= (!rst_n || clr || tc) ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/ele_run_ctrl.sv
// ele_run_ctrl: car motion and door sequencing FSM owning position and run mode
module ele_run_ctrl import ele_pkg::*; #(
  parameter int TRAVEL_CYC = TRAVEL_CYC_DEF,
  parameter int CW = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] all_req,
  input  logic       endOpen,
  output logic [3:0] position,
  output logic [1:0] ud_mode,
  output logic       opendoor,
  output logic       moving,
  output logic       arrive,
  output logic [1:0] floor_bin
);
  state_t state, travel_st;
  logic tc, dir_up;
  logic [3:0] np, ref_p, ahead, behind;
  logic [1:0] travel_mode;
  travel_timer #(.TRAVEL_CYC(TRAVEL_CYC), .CW(CW)) u_timer (
    .clk(clk), .rst_n(rst_n), .en(moving), .clr(~moving), .tc(tc)
  );
  // Travel states look ahead from the next floor; DOOR looks from the current one.
  always_comb begin
    dir_up = state == S_UP || (state == S_DOOR && ud_mode == MODE_UP);
    np = dir_up ? position << 1 : position >> 1;
    ref_p = state == S_DOOR ? position : np;
    ahead = dir_up ? req_above(all_req, ref_p) : req_below(all_req, ref_p);
    behind = dir_up ? req_below(all_req, ref_p) : req_above(all_req, ref_p);
    travel_st = |ahead ? (dir_up ? S_UP : S_DOWN) : |behind ? (dir_up ? S_DOWN : S_UP) : S_IDLE;
    travel_mode = travel_st == S_UP ? MODE_UP : travel_st == S_DOWN ? MODE_DOWN : MODE_STOP;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      position <= FLOOR1;
      ud_mode <= MODE_STOP;
      opendoor <= 1'b0;
      moving <= 1'b0;
      arrive <= 1'b0;
    end else begin
      arrive <= 1'b0;
      case (state)
        S_IDLE:
          if (|(all_req & position)) begin
            state <= S_DOOR;
            opendoor <= 1'b1;
            ud_mode <= position == FLOOR4 ? MODE_DOWN : MODE_UP;
          end else if (|req_above(all_req, position)) begin
            state <= S_UP;
            ud_mode <= MODE_UP;
            moving <= 1'b1;
          end else if (|req_below(all_req, position)) begin
            state <= S_DOWN;
            ud_mode <= MODE_DOWN;
            moving <= 1'b1;
          end
        S_UP, S_DOWN:
          if (tc) begin
            if (np == '0) begin
              state <= S_IDLE;
              ud_mode <= MODE_STOP;
              moving <= 1'b0;
            end else begin
              position <= np;
              arrive <= 1'b1;
              if (|(all_req & np)) begin
                state <= S_DOOR;
                opendoor <= 1'b1;
                moving <= 1'b0;
              end else begin
                state <= travel_st;
                ud_mode <= travel_mode;
                moving <= travel_st != S_IDLE;
              end
            end
          end
        default:
          if (endOpen) begin
            opendoor <= 1'b0;
            state <= travel_st;
            ud_mode <= travel_mode;
            moving <= travel_st != S_IDLE;
          end
      endcase
    end
  end
  assign floor_bin = floor_enc(position);
endmodule
